// File: rtl/alu_subsystem_md.sv
// alu_subsystem_md: single-cycle ALU plus iterative unsigned multiply/divide behind a Start/Busy/Done handshake
module alu_subsystem_md #(
  parameter int WIDTH      = 16,
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] PC_In,
  input  logic [WIDTH-1:0] Imm,
  input  logic             ALU_SrcA,
  input  logic [1:0]       ALU_SrcB,
  input  logic [3:0]       ALU_Op,
  input  logic             Start,
  output logic [WIDTH-1:0] ALU_Result,
  output logic [WIDTH-1:0] ALU_Out,
  output logic [WIDTH-1:0] Hi,
  output logic             Busy,
  output logic             Done,
  output logic             EQ,
  output logic             GR,
  output logic             LT,
  output logic             Zero,
  output logic             Ovfl,
  output logic             DivZero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
  state_t           state;
  logic [WIDTH-1:0] op_a, op_b, sum, diff, mc, hi_r, lo_r, res_lo;
  logic [WIDTH:0]   madd, mstep, dtrial;
  logic [CW-1:0]    cnt;
  logic             is_div, dz, ovf_add, ovf_sub, lt_c;
  always_comb begin
    op_a    = ALU_SrcA ? PC_In : A;
    op_b    = ALU_SrcB == 2'd0 ? B : ALU_SrcB == 2'd1 ? Imm : ALU_SrcB == 2'd2 ? WIDTH'(1) : WIDTH'(2);
    sum     = op_a + op_b;
    diff    = op_a - op_b;
    ovf_add = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
    ovf_sub = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
    lt_c    = SIGNED_CMP ? ($signed(op_a) < $signed(op_b)) : (op_a < op_b);
  end
  always_comb begin
    case (ALU_Op)
      4'd0:    ALU_Result = sum;
      4'd1:    ALU_Result = diff;
      4'd2:    ALU_Result = op_a & op_b;
      4'd3:    ALU_Result = op_a | op_b;
      4'd4:    ALU_Result = ~op_a;
      4'd5:    ALU_Result = op_a << op_b;
      4'd6:    ALU_Result = op_a >> op_b;
      4'd7:    ALU_Result = diff;
      4'd8:    ALU_Result = $signed(op_a) >>> op_b;
      4'd9:    ALU_Result = op_a ^ op_b;
      default: ALU_Result = '0;
    endcase
  end
  // hi_r/lo_r hold partial product or remainder/quotient; mc is multiplicand or divisor
  always_comb begin
    madd   = {1'b0, hi_r} + {1'b0, mc};
    mstep  = lo_r[0] ? madd : {1'b0, hi_r};
    dtrial = {hi_r, lo_r[WIDTH-1]} - {1'b0, mc};
    dz     = is_div && (mc == '0);
    res_lo = dz ? '1 : lo_r;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      ALU_Out <= '0;
      Hi      <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      EQ      <= 1'b0;
      GR      <= 1'b0;
      LT      <= 1'b0;
      Zero    <= 1'b1;
      Ovfl    <= 1'b0;
      DivZero <= 1'b0;
      cnt     <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      mc      <= '0;
      is_div  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          if (ALU_Op == 4'd10 || ALU_Op == 4'd11) begin
            is_div <= ALU_Op[0];
            mc     <= ALU_Op[0] ? op_b : op_a;
            lo_r   <= ALU_Op[0] ? op_a : op_b;
            hi_r   <= '0;
            cnt    <= '0;
            Busy   <= 1'b1;
            state  <= ALU_Op[0] ? DIV : MUL;
          end else begin
            ALU_Out <= ALU_Result;
            Zero    <= ALU_Result == '0;
            EQ      <= op_a == op_b;
            LT      <= lt_c;
            GR      <= !lt_c && (op_a != op_b);
            Ovfl    <= (ALU_Op == 4'd0 && ovf_add) || ((ALU_Op == 4'd1 || ALU_Op == 4'd7) && ovf_sub);
            DivZero <= 1'b0;
            Done    <= 1'b1;
          end
        end
        MUL: begin
          {hi_r, lo_r} <= {mstep, lo_r[WIDTH-1:1]};
          cnt          <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIN;
        end
        DIV: begin
          hi_r  <= dtrial[WIDTH] ? {hi_r[WIDTH-2:0], lo_r[WIDTH-1]} : dtrial[WIDTH-1:0];
          lo_r  <= {lo_r[WIDTH-2:0], ~dtrial[WIDTH]};
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIN;
        end
        FIN: begin
          ALU_Out <= res_lo;
          Hi      <= hi_r;
          Zero    <= res_lo == '0;
          Ovfl    <= !is_div && (hi_r != '0);
          DivZero <= dz;
          Busy    <= 1'b0;
          Done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_subsystem_md.sv
// tb_alu_subsystem_md: vector table, corner sequences and randomized ops against a behavioural model
module tb_alu_subsystem_md;
  logic        Clock = 1'b0, Reset = 1'b1, ALU_SrcA = 1'b0, Start = 1'b0;
  logic [15:0] A = '0, B = '0, PC_In = '0, Imm = '0;
  logic [1:0]  ALU_SrcB = '0;
  logic [3:0]  ALU_Op = '0;
  logic [15:0] ALU_Result, ALU_Out, Hi, res_u, out_u, hi_u;
  logic        Busy, Done, EQ, GR, LT, Zero, Ovfl, DivZero;
  logic        busy_u, done_u, eq_u, gr_u, lt_u, zero_u, ovfl_u, dz_u;
  int          n_cmp = 0, n_fail = 0;
  logic [15:0] m_out, m_hi, m_res;
  logic        m_eq, m_gr, m_lt, m_zero, m_ovfl, m_dz, u_eq, u_gr, u_lt;

  always #5 Clock = ~Clock;

  alu_subsystem_md #(.WIDTH(16), .SIGNED_CMP(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .A(A), .B(B), .PC_In(PC_In), .Imm(Imm),
    .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB), .ALU_Op(ALU_Op), .Start(Start),
    .ALU_Result(ALU_Result), .ALU_Out(ALU_Out), .Hi(Hi), .Busy(Busy), .Done(Done),
    .EQ(EQ), .GR(GR), .LT(LT), .Zero(Zero), .Ovfl(Ovfl), .DivZero(DivZero));

  alu_subsystem_md #(.WIDTH(16), .SIGNED_CMP(1'b0)) dut_u (
    .Clock(Clock), .Reset(Reset), .A(A), .B(B), .PC_In(PC_In), .Imm(Imm),
    .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB), .ALU_Op(ALU_Op), .Start(Start),
    .ALU_Result(res_u), .ALU_Out(out_u), .Hi(hi_u), .Busy(busy_u), .Done(done_u),
    .EQ(eq_u), .GR(gr_u), .LT(lt_u), .Zero(zero_u), .Ovfl(ovfl_u), .DivZero(dz_u));

  typedef struct {
    logic        sa;
    logic [1:0]  sb;
    logic [3:0]  op;
    logic [15:0] a, b, pc, imm, out;
    logic [3:0]  f;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_hi = '0; m_res = '0;
    {m_eq, m_gr, m_lt, m_ovfl, m_dz, u_eq, u_gr, u_lt} = '0;
    m_zero = 1'b1;
  endtask

  task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, sr, sh;
    logic [31:0] r;
    longint p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sr = 0;
    r = '0;
    m_res = '0;
    if (op == 4'd10) begin
      p = longint'(a) * longint'(b);
      m_out = p[15:0];
      m_hi = p[31:16];
      m_ovfl = m_hi != 0;
      m_dz = 1'b0;
    end else if (op == 4'd11) begin
      m_ovfl = 1'b0;
      m_dz = b == 0;
      if (b == 0) begin
        m_out = 16'hFFFF;
        m_hi = a;
      end else begin
        m_out = a / b;
        m_hi = a % b;
      end
    end else begin
      sh = b >= 16 ? 15 : int'(b);
      case (op)
        4'd0: begin r = 32'(a) + 32'(b); sr = sa + sb; end
        4'd1, 4'd7: begin r = 32'(a) - 32'(b); sr = sa - sb; end
        4'd2: r = 32'(a & b);
        4'd3: r = 32'(a | b);
        4'd4: r = 32'(~a);
        4'd5: r = b >= 16 ? 32'd0 : 32'(a) << b;
        4'd6: r = b >= 16 ? 32'd0 : 32'(a) >> b;
        4'd8: r = 32'(sa >>> sh);
        4'd9: r = 32'(a ^ b);
        default: r = '0;
      endcase
      m_res = r[15:0];
      m_out = m_res;
      m_ovfl = (op == 4'd0 || op == 4'd1 || op == 4'd7) && (sr > 32767 || sr < -32768);
      m_dz = 1'b0;
      m_eq = a == b; m_lt = sa < sb; m_gr = sa > sb;
      u_eq = a == b; u_lt = a < b; u_gr = a > b;
    end
    m_zero = m_out == 0;
  endtask

  task automatic do_op(input logic sa, input logic [1:0] sb, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] pc,
                       input logic [15:0] imm, input bit inj);
    logic [15:0] ea, eb;
    int n;
    bit multi, busy_ok;
    ea = sa ? pc : a;
    eb = sb == 2'd0 ? b : sb == 2'd1 ? imm : sb == 2'd2 ? 16'd1 : 16'd2;
    multi = op == 4'd10 || op == 4'd11;
    ALU_SrcA = sa; ALU_SrcB = sb; ALU_Op = op; A = a; B = b; PC_In = pc; Imm = imm;
    model(op, ea, eb);
    #1;
    chk("alu_result", ALU_Result, m_res);
    chk("alu_result_u", res_u, m_res);
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (!Done && n < 40) begin
      if (multi && !Busy) busy_ok = 1'b0;
      if (inj && n == 3) begin
        Start = 1'b1; ALU_Op = 4'd0; A = ~a; B = ~b; PC_In = ~pc; Imm = ~imm;
      end else Start = 1'b0;
      @(posedge Clock); #1;
      n++;
    end
    Start = 1'b0;
    if (multi) chk("busy_during", busy_ok, 1);
    chk("latency", n, multi ? 17 : 0);
    chk("busy_at_done", Busy, 0);
    chk("alu_out", ALU_Out, m_out);
    chk("hi", Hi, m_hi);
    chk("zero", Zero, m_zero);
    chk("ovfl", Ovfl, m_ovfl);
    chk("divzero", DivZero, m_dz);
    chk("flags", {EQ, GR, LT}, {m_eq, m_gr, m_lt});
    chk("flags_u", {eq_u, gr_u, lt_u}, {u_eq, u_gr, u_lt});
    chk("out_u", out_u, m_out);
    chk("misc_u", {hi_u, zero_u, ovfl_u, dz_u, busy_u, done_u}, {m_hi, m_zero, m_ovfl, m_dz, 1'b0, 1'b1});
    @(posedge Clock); #1;
    chk("done_pulse", Done, 0);
  endtask

  initial begin
    vec_t vt[16];
    bit seen;
    vt[0]  = '{0, 0, 0,  16'd10,   16'd5,    0,        0,        16'd15,   4'b0010};
    vt[1]  = '{0, 0, 1,  16'd10,   16'd5,    0,        0,        16'd5,    4'b0010};
    vt[2]  = '{0, 0, 0,  16'h7FFF, 16'd1,    0,        0,        16'h8000, 4'b1010};
    vt[3]  = '{0, 0, 3,  16'hA5A5, 16'h5A5A, 0,        0,        16'hFFFF, 4'b0001};
    vt[4]  = '{0, 0, 5,  16'd1,    16'd1,    0,        0,        16'd2,    4'b0100};
    vt[5]  = '{0, 0, 8,  16'h8000, 16'd20,   0,        0,        16'hFFFF, 4'b0001};
    vt[6]  = '{0, 0, 6,  16'h8000, 16'd20,   0,        0,        16'h0000, 4'b0001};
    vt[7]  = '{0, 0, 7,  16'd2,    16'd1,    0,        0,        16'd1,    4'b0010};
    vt[8]  = '{0, 0, 7,  16'd2,    16'd2,    0,        0,        16'd0,    4'b0100};
    vt[9]  = '{0, 0, 7,  16'hFFFF, 16'd1,    0,        0,        16'hFFFE, 4'b0001};
    vt[10] = '{1, 3, 0,  16'd0,    16'd0,    16'h0040, 0,        16'h0042, 4'b0010};
    vt[11] = '{0, 1, 2,  16'hF0F0, 16'd0,    0,        16'h0FF0, 16'h00F0, 4'b0001};
    vt[12] = '{0, 0, 12, 16'd5,    16'd5,    0,        0,        16'h0000, 4'b0100};
    vt[13] = '{0, 0, 1,  16'h8000, 16'd1,    0,        0,        16'h7FFF, 4'b1001};
    vt[14] = '{0, 2, 9,  16'h00FF, 16'h1234, 0,        0,        16'h00FE, 4'b0010};
    vt[15] = '{0, 0, 4,  16'h1234, 16'd0,    0,        0,        16'hEDCB, 4'b0010};

    model_reset();
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;
    chk("rst_out", ALU_Out, 16'h0000);
    chk("rst_hi", Hi, 16'h0000);
    chk("rst_ctl", {Busy, Done, EQ, GR, LT, Zero, Ovfl, DivZero}, 8'b0000_0100);

    for (int i = 0; i < 16; i++) begin
      do_op(vt[i].sa, vt[i].sb, vt[i].op, vt[i].a, vt[i].b, vt[i].pc, vt[i].imm, 0);
      chk($sformatf("vec%0d_out", i), ALU_Out, vt[i].out);
      chk($sformatf("vec%0d_flags", i), {Ovfl, EQ, GR, LT}, vt[i].f);
      chk($sformatf("vec%0d_zero", i), Zero, vt[i].out == 16'h0000);
    end

    do_op(0, 0, 7, 16'hFFFF, 16'd1, 0, 0, 0);
    chk("ucmp_gr", {eq_u, gr_u, lt_u}, 3'b010);

    do_op(0, 0, 10, 16'h1234, 16'h0100, 0, 0, 1);
    chk("mul_lo", ALU_Out, 16'h3400);
    chk("mul_hi", Hi, 16'h0012);
    chk("mul_ovfl", Ovfl, 1);

    do_op(0, 0, 11, 16'd100, 16'd7, 0, 0, 0);
    chk("div_q", ALU_Out, 16'd14);
    chk("div_r", Hi, 16'd2);
    do_op(0, 0, 11, 16'd100, 16'd0, 0, 0, 1);
    chk("div0_q", ALU_Out, 16'hFFFF);
    chk("div0_r", Hi, 16'd100);
    chk("div0_flag", DivZero, 1);
    do_op(0, 0, 0, 16'd3, 16'd4, 0, 0, 0);
    chk("div0_clear", DivZero, 0);
    chk("hi_held", Hi, 16'd100);

    ALU_SrcA = 0; ALU_SrcB = 0; ALU_Op = 4'd0; A = 16'd1; B = 16'd2; Start = 1'b1;
    model(4'd0, 16'd1, 16'd2);
    @(posedge Clock); #1;
    chk("b2b_first", {Done, ALU_Out}, {1'b1, 16'd3});
    ALU_Op = 4'd1; A = 16'd9; B = 16'd4;
    model(4'd1, 16'd9, 16'd4);
    @(posedge Clock); #1;
    Start = 1'b0;
    chk("b2b_second", {Done, ALU_Out, GR}, {1'b1, 16'd5, 1'b1});
    @(posedge Clock); #1;
    chk("b2b_idle", Done, 0);

    ALU_Op = 4'd10; A = 16'hFFFF; B = 16'hFFFF; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (5) @(posedge Clock);
    #1;
    chk("rst_mid_busy", Busy, 1);
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    model_reset();
    chk("rst_mid_state", {Busy, Done, Zero, ALU_Out, Hi}, {1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000});
    seen = 1'b0;
    repeat (25) begin
      @(posedge Clock); #1;
      if (Done) seen = 1'b1;
    end
    chk("rst_mid_no_done", seen, 0);
    do_op(1, 3, 0, 16'h1111, 16'h2222, 16'h0040, 16'h0000, 0);
    chk("src_pc_const2", ALU_Out, 16'h0042);

    for (int i = 0; i < 60; i++) begin
      logic [15:0] rb;
      rb = i % 4 == 0 ? 16'($urandom_range(0, 20)) : i % 7 == 0 ? 16'd0 : 16'($urandom);
      do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            16'($urandom), rb, 16'($urandom), i % 3 == 0 ? rb : 16'($urandom), i % 5 == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_subsystem_md.md
Name: alu_subsystem_md

Overview:
Parametrised successor to the MERC-16 ALU subsystem. It supports single-cycle arithmetic, logic and shift ops, plus iterative multi-cycle unsigned multiply and divide. Operand source muxing, registered result (ALU_Out) and a Hi register sit behind a Start/Busy/Done handshake, so the control FSM can stall on long ops. It sits between the register file/immediate extenders and the writeback mux in the datapath.

Parameters:
WIDTH, 16, datapath width in bits (≥4, power of 2)
SIGNED_CMP, 1, 1 = compare op and GR/LT use two's-complement ordering; 0 = unsigned

Ports:
Clock  in  1  system clock, all state updates on rising edge
Reset  in  1  synchronous, active-high; clears all state
A  in  WIDTH  register operand A
B  in  WIDTH  register operand B
PC_In  in  WIDTH  program counter, alternate A source
Imm  in  WIDTH  already-extended immediate
ALU_SrcA  in  1  0 = A, 1 = PC_In
ALU_SrcB  in  2  0 = B, 1 = Imm, 2 = constant 1, 3 = constant 2
ALU_Op  in  4  op select (see Behaviour)
Start  in  1  launch op on sampled operands
ALU_Result  out  WIDTH  combinational result of single-cycle op on current operands
ALU_Out  out  WIDTH  registered result / low product / quotient
Hi  out  WIDTH  registered high product / remainder
Busy  out  1  multi-cycle op in progress
Done  out  1  one-cycle pulse: ALU_Out/flags valid, new this cycle
EQ, GR, LT  out  1  registered compare flags (opA vs opB)
Zero  out  1  registered: ALU_Out == 0
Ovfl  out  1  registered overflow
DivZero  out  1  registered: last divide had opB == 0

Behaviour:
- opA = ALU_SrcA ? PC_In : A. opB is selected by ALU_SrcB. Both are all-WIDTH arithmetic.
- Ops: 0 add, 1 sub (opA−opB), 2 and, 3 or, 4 not opA, 5 shl, 6 shr (logical), 7 cmp (ALU_Result = opA−opB, flags only), 8 sra, 9 xor, 10 mul (unsigned), 11 divu. Ops 12–15 give result 0 and act as single-cycle ops.
- Shifts: the amount is the full opB value. If opB ≥ WIDTH, shl/shr give 0 and sra gives all copies of opA[WIDTH-1].
- Ovfl: signed overflow for add/sub/cmp; for mul, set when the high half ≠ 0; 0 for all other ops.
- Reset values: ALU_Out = 0, Hi = 0, Busy = 0, Done = 0, EQ = GR = LT = 0, Zero = 1, Ovfl = 0, DivZero = 0, FSM state = IDLE.
- FSM states: IDLE, MUL, DIV, FIN.
- IDLE with Start and a single-cycle op: at the next edge ALU_Out, flags and Zero load; Done = 1 for exactly the following cycle; Hi is unchanged; state stays IDLE (back-to-back Starts are allowed every cycle).
- IDLE with Start and op 10/11: latch opA, opB and the op; clear the counter; Busy = 1 from the next edge; go to MUL or DIV.
- MUL: one shift-add step per cycle. After WIDTH steps go to FIN.
- DIV: one restoring step per cycle. After WIDTH steps go to FIN.
- Multi-cycle latency: result registers are written WIDTH+1 edges after the Start edge. At that FIN edge Busy drops and Done pulses for one cycle, then state returns to IDLE.
- Mul result: {Hi, ALU_Out} = opA × opB (2·WIDTH bits).
- Divu result: ALU_Out = quotient, Hi = remainder.
- Divide by zero: still WIDTH+1 cycles. Result is ALU_Out = all ones, Hi = opA, DivZero = 1. DivZero clears on the next completed op.
- Multi-cycle flags: EQ, GR and LT hold their previous values. Zero reflects ALU_Out.
- Start while Busy: ignored. Operand changes during Busy have no effect because operands were latched.
- Reset asserted mid-operation aborts the op: return to the reset values at that edge, and no Done is issued.
- ALU_Result is combinational for ops 0–9 and is independent of Start and Busy. It is 0 for ops 10–15.
- Outputs hold their values between ops.

Test Plan:
- Add/sub (WIDTH=16): A=10, B=5, SrcA=0, SrcB=0, Start op0 → next cycle ALU_Out=15, Done=1 for one cycle. Then op1 → ALU_Out=5. Then A=16'h7FFF, B=1, op0 → ALU_Out=16'h8000, Ovfl=1.
- Logic/shift: A=16'hA5A5, B=16'h5A5A, op3 → 16'hFFFF. Then A=1, B=1, op5 → 2. Then A=16'h8000, B=20, op8 → 16'hFFFF; op6 with B=20 → 0.
- Compare, SIGNED_CMP=1: (A=2, B=1) → GR=1. (A=2, B=2) → EQ=1, Zero=1. (A=16'hFFFF, B=1) → LT=1. With SIGNED_CMP=0, (A=16'hFFFF, B=1) → GR=1.
- Multiply: A=16'h1234, B=16'h0100, op10, Start → Busy for 16 cycles, Done on cycle 17, ALU_Out=16'h3400, Hi=16'h0012, Ovfl=1. A Start pulsed mid-op is ignored.
- Divide: A=100, B=7, op11 → ALU_Out=14, Hi=2 after 17 cycles. Then B=0 → ALU_Out=16'hFFFF, Hi=100, DivZero=1. Then op0 → DivZero=0.
- Reset mid-op and sources: assert Reset 5 cycles into a mul → Busy=0, ALU_Out=0, Zero=1, and no Done follows. Then SrcA=1, PC_In=16'h0040, SrcB=3, op0 → ALU_Out=16'h0042.
